// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard control: compares decode sources with the EX/MEM destination tags. Selects are registered into EX one clock after decode; o_stall is same-cycle combinational.
// With `FWD_HAZARD_FORWARD_EN defined, selects forward from MEM/WB and only load-use stalls (1 cycle); otherwise selects stay 00 and any EX/MEM hit stalls until WB.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_en,
  input  logic              i_id_rs2_en,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_rd_wren,
  input  logic              i_id_is_load,
  input  logic              i_flush,
  output logic [1:0]        o_fwd_sel_a,
  output logic [1:0]        o_fwd_sel_b,
  output logic              o_stall,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              wren;
    logic              is_load;
  } tag_t;

  tag_t r_ex;
  tag_t r_mem;
  tag_t r_wb;
  tag_t w_id_tag;

  logic w_a_ex;
  logic w_a_mem;
  logic w_b_ex;
  logic w_b_mem;
  logic w_stall;
  logic w_issue;

  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic f_match(input tag_t t, input logic [REG_AW-1:0] rs,
                                   input logic en, input logic id_vld);
    return t.vld && t.wren && (t.rd == rs) && (rs != '0) && en && id_vld;
  endfunction

  assign w_a_ex  = f_match(r_ex,  i_id_rs1, i_id_rs1_en, i_id_valid);
  assign w_a_mem = f_match(r_mem, i_id_rs1, i_id_rs1_en, i_id_valid);
  assign w_b_ex  = f_match(r_ex,  i_id_rs2, i_id_rs2_en, i_id_valid);
  assign w_b_mem = f_match(r_mem, i_id_rs2, i_id_rs2_en, i_id_valid);

`ifdef FWD_HAZARD_FORWARD_EN
  // Only a load in EX has no result yet; everything else is forwarded.
  assign w_stall = !i_flush && r_ex.is_load && (w_a_ex || w_b_ex);
`else
  assign w_stall = !i_flush && (w_a_ex || w_a_mem || w_b_ex || w_b_mem);
`endif

  assign o_stall = w_stall;
  assign w_issue = i_id_valid && !w_stall && !i_flush;

  always_comb begin
    w_id_tag = '0;
    if (w_issue) begin
      w_id_tag.vld     = 1'b1;
      w_id_tag.rd      = i_id_rd;
      w_id_tag.wren    = i_id_rd_wren;
      w_id_tag.is_load = i_id_is_load;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_id_tag;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  // WB producers reach decode through the regfile's write-first bypass, so no compare reads this.
  logic w_unused_tags;
  assign w_unused_tags = ^{r_wb, r_mem.is_load, r_ex.is_load};

`ifdef FWD_HAZARD_FORWARD_EN
  logic [1:0] w_sel_a_nxt;
  logic [1:0] w_sel_b_nxt;
  logic [1:0] r_sel_a;
  logic [1:0] r_sel_b;

  always_comb begin
    w_sel_a_nxt = 2'b00;
    w_sel_b_nxt = 2'b00;
    if (w_issue) begin
      if (w_a_ex)       w_sel_a_nxt = 2'b01;
      else if (w_a_mem) w_sel_a_nxt = 2'b10;
      if (w_b_ex)       w_sel_b_nxt = 2'b01;
      else if (w_b_mem) w_sel_b_nxt = 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sel_a <= 2'b00;
      r_sel_b <= 2'b00;
    end else begin
      r_sel_a <= w_sel_a_nxt;
      r_sel_b <= w_sel_b_nxt;
    end
  end

  assign o_fwd_sel_a = r_sel_a;
  assign o_fwd_sel_b = r_sel_b;
`else
  assign o_fwd_sel_a = 2'b00;
  assign o_fwd_sel_b = 2'b00;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: cycle-indexed issue log model plus directed instruction sequences.
module tb_fwd_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int NC     = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_rs1_en;
  logic              i_id_rs2_en;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_rd_wren;
  logic              i_id_is_load;
  logic              i_flush;
  logic [1:0]        o_fwd_sel_a;
  logic [1:0]        o_fwd_sel_b;
  logic              o_stall;
  logic [CNT_W-1:0]  o_stall_cnt;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_id_valid  (i_id_valid),
    .i_id_rs1    (i_id_rs1),
    .i_id_rs2    (i_id_rs2),
    .i_id_rs1_en (i_id_rs1_en),
    .i_id_rs2_en (i_id_rs2_en),
    .i_id_rd     (i_id_rd),
    .i_id_rd_wren(i_id_rd_wren),
    .i_id_is_load(i_id_is_load),
    .i_flush     (i_flush),
    .o_fwd_sel_a (o_fwd_sel_a),
    .o_fwd_sel_b (o_fwd_sel_b),
    .o_stall     (o_stall),
    .o_stall_cnt (o_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: log of what was issued into EX at the end of each cycle.
  // A producer issued k cycles ago sits in EX (k=1) or MEM (k=2) unless a reset came since.
  logic            iss_vld [NC];
  logic [REG_AW-1:0] iss_rd [NC];
  logic            iss_wr  [NC];
  logic            iss_ld  [NC];
  int              cyc      = 1;
  int              last_rst = -1;
  bit              model_ok = 1'b0;
  logic [1:0]      exp_sel_a = 2'b00;
  logic [1:0]      exp_sel_b = 2'b00;
  int              exp_cnt   = 0;

  function automatic logic hit(input int d, input logic [REG_AW-1:0] rs, input logic en);
    int k;
    k = cyc - d;
    if (k < 0 || k <= last_rst) return 1'b0;
    return iss_vld[k] && iss_wr[k] && (iss_rd[k] == rs) && (rs != 0) && en && i_id_valid;
  endfunction

  always @(negedge clk) begin : cmp
    logic h1a, h1b, h2a, h2b, st;
    h1a = hit(1, i_id_rs1, i_id_rs1_en);
    h1b = hit(1, i_id_rs2, i_id_rs2_en);
    h2a = hit(2, i_id_rs1, i_id_rs1_en);
    h2b = hit(2, i_id_rs2, i_id_rs2_en);
`ifdef FWD_HAZARD_FORWARD_EN
    st = !i_flush && (h1a || h1b) && iss_ld[cyc-1];
`else
    st = !i_flush && (h1a || h1b || h2a || h2b);
`endif
    if (model_ok) begin
      chk("stall", {31'b0, o_stall}, {31'b0, st});
      chk("sel_a", {30'b0, o_fwd_sel_a}, {30'b0, exp_sel_a});
      chk("sel_b", {30'b0, o_fwd_sel_b}, {30'b0, exp_sel_b});
      chk("stall_cnt", {29'b0, o_stall_cnt}, exp_cnt);
    end
    if (!rst_n) begin
      exp_sel_a = 2'b00;
      exp_sel_b = 2'b00;
      exp_cnt   = 0;
      last_rst  = cyc;
      iss_vld[cyc] = 1'b0;
      model_ok  = 1'b1;
    end else begin
      if (st) exp_cnt = (exp_cnt >= MAXC) ? MAXC : exp_cnt + 1;
      iss_vld[cyc] = i_id_valid && !st && !i_flush;
      iss_rd[cyc]  = i_id_rd;
      iss_wr[cyc]  = i_id_rd_wren;
      iss_ld[cyc]  = i_id_is_load;
`ifdef FWD_HAZARD_FORWARD_EN
      if (i_flush || st) begin
        exp_sel_a = 2'b00;
        exp_sel_b = 2'b00;
      end else begin
        exp_sel_a = h1a ? 2'b01 : (h2a ? 2'b10 : 2'b00);
        exp_sel_b = h1b ? 2'b01 : (h2b ? 2'b10 : 2'b00);
      end
`else
      exp_sel_a = 2'b00;
      exp_sel_b = 2'b00;
`endif
    end
    if (cyc < NC - 1) cyc++;
  end

  task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                       input logic [4:0] rs1, input logic e1, input logic [4:0] rs2,
                       input logic e2, input logic fl);
    i_id_valid   = v;
    i_id_rd      = rd;
    i_id_rd_wren = wr;
    i_id_is_load = ld;
    i_id_rs1     = rs1;
    i_id_rs1_en  = e1;
    i_id_rs2     = rs2;
    i_id_rs2_en  = e2;
    i_flush      = fl;
  endtask

  // One decode cycle; returns at the falling edge with the inputs applied.
  task automatic dec(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                     input logic [4:0] rs1, input logic e1, input logic [4:0] rs2,
                     input logic e2, input logic fl);
    @(posedge clk); #1;
    drive(v, rd, wr, ld, rs1, e1, rs2, e2, fl);
    @(negedge clk);
  endtask

  task automatic nop();
    dec(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < NC; i++) iss_vld[i] = 1'b0;

    do_reset();
    chk("rst_sel_a", {30'b0, o_fwd_sel_a}, 0);
    chk("rst_sel_b", {30'b0, o_fwd_sel_b}, 0);
    chk("rst_stall", {31'b0, o_stall}, 0);
    chk("rst_cnt", {29'b0, o_stall_cnt}, 0);

    // add x5,x1,x2 ; sub x6,x5,x7
    dec(1, 5, 1, 0, 1, 1, 2, 1, 0);
    dec(1, 6, 1, 0, 5, 1, 7, 1, 0);
`ifdef FWD_HAZARD_FORWARD_EN
    chk("exex_stall", {31'b0, o_stall}, 0);
    nop();
    chk("exex_sel_a", {30'b0, o_fwd_sel_a}, 1);
    chk("exex_sel_b", {30'b0, o_fwd_sel_b}, 0);
`else
    chk("nf_stall1", {31'b0, o_stall}, 1);
    dec(1, 6, 1, 0, 5, 1, 7, 1, 0);
    chk("nf_stall2", {31'b0, o_stall}, 1);
    chk("nf_cnt1", {29'b0, o_stall_cnt}, 1);
    dec(1, 6, 1, 0, 5, 1, 7, 1, 0);
    chk("nf_stall3", {31'b0, o_stall}, 0);
    nop();
    chk("nf_sel_a", {30'b0, o_fwd_sel_a}, 0);
    chk("nf_cnt2", {29'b0, o_stall_cnt}, 2);
`endif

    // add x5 ; nop ; or x8,x5,x5
    do_reset();
`ifdef FWD_HAZARD_FORWARD_EN
    chk("rst2_sel_a", {30'b0, o_fwd_sel_a}, 0);
`endif
    dec(1, 5, 1, 0, 1, 1, 2, 1, 0);
    nop();
    dec(1, 8, 1, 0, 5, 1, 5, 1, 0);
    nop();
`ifdef FWD_HAZARD_FORWARD_EN
    chk("mem_sel_a", {30'b0, o_fwd_sel_a}, 2);
    chk("mem_sel_b", {30'b0, o_fwd_sel_b}, 2);
`endif

    // add x5 ; addi x5,x0,1 ; or x8,x5,x0
    do_reset();
    dec(1, 5, 1, 0, 1, 1, 2, 1, 0);
    dec(1, 5, 1, 0, 0, 1, 0, 0, 0);
    dec(1, 8, 1, 0, 5, 1, 0, 1, 0);
    nop();
`ifdef FWD_HAZARD_FORWARD_EN
    chk("near_sel_a", {30'b0, o_fwd_sel_a}, 1);
    chk("near_sel_b", {30'b0, o_fwd_sel_b}, 0);
`endif

    // lw x3 ; and x4,x3,x2
    do_reset();
    dec(1, 3, 1, 1, 1, 1, 0, 0, 0);
    dec(1, 4, 1, 0, 3, 1, 2, 1, 0);
    chk("lu_stall", {31'b0, o_stall}, 1);
    chk("lu_cnt0", {29'b0, o_stall_cnt}, 0);
    dec(1, 4, 1, 0, 3, 1, 2, 1, 0);
`ifdef FWD_HAZARD_FORWARD_EN
    chk("lu_release", {31'b0, o_stall}, 0);
    chk("lu_bubble", {30'b0, o_fwd_sel_a}, 0);
    chk("lu_cnt1", {29'b0, o_stall_cnt}, 1);
    nop();
    chk("lu_sel_a", {30'b0, o_fwd_sel_a}, 2);
    chk("lu_sel_b", {30'b0, o_fwd_sel_b}, 0);
`else
    chk("nf_lu_stall2", {31'b0, o_stall}, 1);
    dec(1, 4, 1, 0, 3, 1, 2, 1, 0);
    chk("nf_lu_release", {31'b0, o_stall}, 0);
    chk("nf_lu_cnt", {29'b0, o_stall_cnt}, 2);
`endif

    // add x0 ; consumer of x0
    do_reset();
    dec(1, 0, 1, 0, 1, 1, 2, 1, 0);
    dec(1, 9, 1, 0, 0, 1, 0, 1, 0);
    chk("x0_stall", {31'b0, o_stall}, 0);
    nop();
    chk("x0_sel_a", {30'b0, o_fwd_sel_a}, 0);
    chk("x0_sel_b", {30'b0, o_fwd_sel_b}, 0);

    // lw x3 ; and x4,x3,x2 flushed
    do_reset();
    dec(1, 3, 1, 1, 1, 1, 0, 0, 0);
    dec(1, 4, 1, 0, 3, 1, 2, 1, 1);
    chk("fl_stall", {31'b0, o_stall}, 0);
    nop();
    chk("fl_sel_a", {30'b0, o_fwd_sel_a}, 0);
    chk("fl_cnt", {29'b0, o_stall_cnt}, 0);

    // add x5 ; add x6 ; or x7,x5,x6
    do_reset();
    dec(1, 5, 1, 0, 1, 1, 2, 1, 0);
    dec(1, 6, 1, 0, 1, 1, 2, 1, 0);
    dec(1, 7, 1, 0, 5, 1, 6, 1, 0);
    nop();
`ifdef FWD_HAZARD_FORWARD_EN
    chk("split_sel_a", {30'b0, o_fwd_sel_a}, 2);
    chk("split_sel_b", {30'b0, o_fwd_sel_b}, 1);
`endif

    // reset asserted while a load-use stall is pending
    do_reset();
    dec(1, 3, 1, 1, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 4, 1, 0, 3, 1, 2, 1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_stall_on", {31'b0, o_stall}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_stall_off", {31'b0, o_stall}, 0);
    chk("mrst_cnt", {29'b0, o_stall_cnt}, 0);

    // stall counter saturation
    do_reset();
`ifdef FWD_HAZARD_FORWARD_EN
    repeat (9) begin
      dec(1, 3, 1, 1, 1, 1, 0, 0, 0);
      dec(1, 4, 1, 0, 3, 1, 2, 1, 0);
      dec(1, 4, 1, 0, 3, 1, 2, 1, 0);
    end
`else
    repeat (4) begin
      dec(1, 5, 1, 0, 1, 1, 2, 1, 0);
      dec(1, 6, 1, 0, 5, 1, 7, 1, 0);
      dec(1, 6, 1, 0, 5, 1, 7, 1, 0);
      dec(1, 6, 1, 0, 5, 1, 7, 1, 0);
    end
`endif
    nop();
    chk("sat_cnt", {29'b0, o_stall_cnt}, MAXC);

    nop();
    nop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipelined forwarding/hazard controller for the 5-stage core. It tracks destination-register tags of in-flight instructions (EX, MEM, WB) and compares them against the source registers of the instruction in decode. From that comparison it drives the registered operand-mux selects consumed in EX and a load-use stall/bubble request toward the fetch/decode pipeline registers. It is the control end of the datapath operand multiplexers: they consume selects, this block produces them.

## Interface

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall-counter width

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_id_valid  in  1  decode slot holds a real instruction
- i_id_rs1  in  REG_AW  decode source register 1
- i_id_rs2  in  REG_AW  decode source register 2
- i_id_rs1_en  in  1  rs1 is read by this instruction
- i_id_rs2_en  in  1  rs2 is read by this instruction
- i_id_rd  in  REG_AW  decode destination register
- i_id_rd_wren  in  1  instruction writes rd
- i_id_is_load  in  1  instruction is a load
- i_flush  in  1  taken branch/jump resolved in EX; squash decode instruction
- o_fwd_sel_a  out  2  EX operand-A mux select: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- o_fwd_sel_b  out  2  same for operand B
- o_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- o_stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation

- Internal tag pipeline: three entries {valid, rd, wren, is_load} for EX, MEM, WB. Each cycle, WB←MEM and MEM←EX.
- EX←decode info when i_id_valid && !o_stall && !i_flush. Otherwise EX←bubble (valid=0).
- A tag "matches" rsX when: tag valid, wren=1, rd==rsX, rsX!=0, rsX_en=1, and i_id_valid=1.
- Select computed in decode and registered into EX with the instruction:
  - Match against current EX tag (goes to MEM next cycle) → 01.
  - Otherwise match against current MEM tag → 10.
  - Otherwise → 00.
  - Nearest stage wins.
  - WB-stage producers are covered by the regfile's write-first bypass.
- Load-use: o_stall=1 when either source matches the EX tag and that tag has is_load=1. Selects registered during a stall are 00 (bubble).
  - After one stall cycle the load is in MEM, so the decode compare hits MEM → select 10.
- i_flush has priority over o_stall. When i_flush=1: o_stall=0, EX←bubble, selects←00.
- o_stall_cnt increments each cycle o_stall=1. It saturates at all-ones.
- x0 is never forwarded and never causes a stall.

## Timing

- o_stall is combinational from the decode inputs and the EX tag, same cycle. No registered output path.
- o_fwd_sel_a/b are registered. They are valid in the cycle the instruction occupies EX, one clock after decode.
- Load-use hazard: exactly 1 stall cycle with forwarding compiled in.
- Reset (i_reset=0 at a rising edge):
  - All tags invalid.
  - o_fwd_sel_a/b=00.
  - o_stall_cnt=0.
  - o_stall=0 follows, since the EX tag is invalid.
- Reset mid-stall clears the stall on the next cycle. In-flight tags are discarded.
- Simultaneous rs1 and rs2 hazards on different stages: each select resolves independently.
- Same register on rs1 and rs2: both selects are equal.

## Configuration

- FWD_HAZARD_FORWARD_EN defined: forwarding as described; load-use costs 1 stall.
- Not defined: o_fwd_sel_a/b tied to 00.
  - o_stall=1 whenever any source matches the EX or MEM tag, regardless of load.
  - Stall persists until the producer reaches WB, where the write-first regfile supplies the value.
  - Back-to-back dependent ALU instructions therefore cost 2 stall cycles.

## Test plan

- Reset: hold i_reset=0 for 2 cycles with arbitrary inputs → sel_a=sel_b=00, o_stall=0, o_stall_cnt=0.
- EX→EX forward: `add x5,…` then `sub x6,x5,x7` → sel_a=01, sel_b=00 in sub's EX cycle, no stall.
- MEM forward and priority:
  - `add x5`, `nop`, `or x8,x5,x5` → sel_a=sel_b=10.
  - `add x5`, `addi x5`, `or x8,x5,x0` → sel_a=01 (nearest wins), sel_b=00.
- Load-use: `lw x3` then `and x4,x3,x2` → o_stall=1 for exactly 1 cycle, bubble in EX, then sel_a=10, o_stall_cnt=1.
- x0 and flush:
  - Producer rd=x0 followed by a consumer of x0 → sel=00, no stall.
  - `lw x3` with i_flush=1 in the consumer's decode cycle → o_stall=0, EX bubble.
- Macro undefined: `add x5` then `sub x6,x5,x7` → o_stall=1 for 2 cycles, sel_a=00, o_stall_cnt=2.
